// File: rtl/periph_addr_decoder_pipe.sv
// Cluster peripheral address decoder: maps a request address to a crossbar output index
// through one registered valid/ready stage, with HWPE enable mask and saturating error count.
module periph_addr_decoder_pipe #(
   parameter bit                ADDREXT            = 1'b0,
   parameter logic [7:0]        CLUSTER_BASE       = 8'h10,
   parameter bit                CLUSTER_ALIAS      = 1'b0,
   parameter logic [11:0]       CLUSTER_ALIAS_BASE = 12'h000,
   parameter int unsigned       SLOT_LSB           = 10,
   parameter int unsigned       N_OUPS             = 16,
   parameter int unsigned       EXT_IDX            = 8,
   parameter int unsigned       HWPE_SLOT_START    = 9,
   parameter int unsigned       HWPE_FIRST_IDX     = 9,
   parameter int unsigned       N_HWPE             = 4,
   parameter logic [N_HWPE-1:0] HWPE_EN_RST        = '1,
   localparam int unsigned      IW                 = $clog2(N_OUPS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       addrext_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [IW-1:0]     out_idx_o,
   output logic              out_err_o,
   output logic [31:0]       out_addr_o,
   input  logic              cfg_we_i,
   input  logic [N_HWPE-1:0] cfg_mask_i,
   output logic [N_HWPE-1:0] cfg_mask_o,
   input  logic              cfg_clr_i,
   output logic [15:0]       err_cnt_o
);

   logic              r_valid;
   logic [IW-1:0]     r_idx;
   logic              r_err;
   logic [31:0]       r_addr;
   logic [N_HWPE-1:0] r_mask;
   logic [15:0]       r_err_cnt;

   logic              w_accept;
   logic              w_ext;
   logic              w_cluster_hit;
   logic              w_window;
   logic [3:0]        w_slot;
   logic [4:0]        w_hs;
   logic [4:0]        w_h;
   logic              w_hwpe_ok;
   logic [4:0]        w_idx;
   logic              w_err;

   assign req_ready_o = !r_valid || out_ready_i;
   assign w_accept    = req_valid_i && req_ready_o;

   assign w_ext         = ADDREXT && (addrext_i != 32'h0);
   assign w_cluster_hit = (addr_i[31:24] == CLUSTER_BASE) ||
                          (CLUSTER_ALIAS && (addr_i[31:24] == CLUSTER_ALIAS_BASE[11:4]));
   assign w_window      = w_cluster_hit && ((addr_i[23:20] == 4'h2) || (addr_i[23:20] == 4'h3));
   assign w_slot        = addr_i[SLOT_LSB+3 -: 4];
   assign w_hs          = addr_i[SLOT_LSB+3 -: 5];
   // Only consumed when slot >= HWPE_SLOT_START, so this subtraction never wraps in use.
   assign w_h           = w_hs - 5'(2 * HWPE_SLOT_START);

   always_comb begin
      w_hwpe_ok = 1'b0;
      for (int unsigned k = 0; k < N_HWPE; k++) begin
         if (w_h == 5'(k)) w_hwpe_ok = r_mask[k];
      end
   end

   always_comb begin
      w_idx = 5'(EXT_IDX);
      w_err = 1'b0;
      if (w_ext) begin
         w_idx = 5'(EXT_IDX);
      end else if (w_window) begin
         if ({1'b0, w_slot} < 5'(HWPE_SLOT_START)) begin
            w_idx = {1'b0, w_slot};
         end else if (w_hwpe_ok) begin
            w_idx = 5'(HWPE_FIRST_IDX) + w_h;
         end else begin
            w_err = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid   <= 1'b0;
         r_idx     <= '0;
         r_err     <= 1'b0;
         r_addr    <= '0;
         r_mask    <= HWPE_EN_RST;
         r_err_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_valid <= 1'b1;
            r_idx   <= IW'(w_idx);
            r_err   <= w_err;
            r_addr  <= addr_i;
         end else if (out_ready_i) begin
            r_valid <= 1'b0;
         end
         if (cfg_we_i) r_mask <= cfg_mask_i;
         if (cfg_clr_i) begin
            r_err_cnt <= '0;
         end else if (w_accept && w_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   assign out_valid_o = r_valid;
   assign out_idx_o   = r_idx;
   assign out_err_o   = r_err;
   assign out_addr_o  = r_addr;
   assign cfg_mask_o  = r_mask;
   assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_periph_addr_decoder_pipe.sv
// Directed bench for periph_addr_decoder_pipe; extended-address and alias windows enabled
// (alias base 12'h1B0) so every decode path is reachable from one instance.
module tb_periph_addr_decoder_pipe;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] addr_i;
   logic [31:0] addrext_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [3:0]  out_idx_o;
   logic        out_err_o;
   logic [31:0] out_addr_o;
   logic        cfg_we_i;
   logic [3:0]  cfg_mask_i;
   logic [3:0]  cfg_mask_o;
   logic        cfg_clr_i;
   logic [15:0] err_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   periph_addr_decoder_pipe #(
      .ADDREXT           (1'b1),
      .CLUSTER_ALIAS     (1'b1),
      .CLUSTER_ALIAS_BASE(12'h1B0)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .addr_i     (addr_i),
      .addrext_i  (addrext_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_idx_o  (out_idx_o),
      .out_err_o  (out_err_o),
      .out_addr_o (out_addr_o),
      .cfg_we_i   (cfg_we_i),
      .cfg_mask_i (cfg_mask_i),
      .cfg_mask_o (cfg_mask_o),
      .cfg_clr_i  (cfg_clr_i),
      .err_cnt_o  (err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [3:0] idx, input logic e);
      chk({tag, ".valid"}, 32'(out_valid_o), 32'(v));
      chk({tag, ".idx"},   32'(out_idx_o),   32'(idx));
      chk({tag, ".err"},   32'(out_err_o),   32'(e));
   endtask

   initial begin
      rst_i = 1'b1; req_valid_i = 1'b0; addr_i = '0; addrext_i = '0; out_ready_i = 1'b0;
      cfg_we_i = 1'b0; cfg_mask_i = '0; cfg_clr_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0;
      chk_out("reset", 1'b0, 4'd0, 1'b0);
      chk("reset.addr", out_addr_o, 32'h0);
      chk("reset.mask", 32'(cfg_mask_o), 32'hF);
      chk("reset.cnt", 32'(err_cnt_o), 32'h0);
      chk("reset.ready", 32'(req_ready_o), 32'h1);

      // Generic slots, latency 1
      req_valid_i = 1'b1; out_ready_i = 1'b1; addr_i = 32'h1020_0400;
      tick();
      chk_out("slot1", 1'b1, 4'd1, 1'b0);
      chk("slot1.addr", out_addr_o, 32'h1020_0400);
      addr_i = 32'h1030_0000;
      tick();
      chk_out("slot0_w3", 1'b1, 4'd0, 1'b0);

      // HWPE half-slots back-to-back
      addr_i = 32'h1020_2400;
      tick();
      chk_out("hwpe0", 1'b1, 4'd9, 1'b0);
      addr_i = 32'h1020_2600;
      tick();
      chk_out("hwpe1", 1'b1, 4'd10, 1'b0);

      // Unmapped half-slot h=6
      addr_i = 32'h1020_3000;
      tick();
      chk_out("h6", 1'b1, 4'd8, 1'b1);
      chk("h6.cnt", 32'(err_cnt_o), 32'd1);

      // Mask write in same cycle decodes with old mask
      cfg_we_i = 1'b1; cfg_mask_i = 4'b1101; addr_i = 32'h1020_2600;
      tick();
      cfg_we_i = 1'b0;
      chk_out("mask_same", 1'b1, 4'd10, 1'b0);
      chk("mask_same.cnt", 32'(err_cnt_o), 32'd1);
      chk("mask_same.mask", 32'(cfg_mask_o), 32'hD);
      tick();
      chk_out("mask_off", 1'b1, 4'd8, 1'b1);
      chk("mask_off.cnt", 32'(err_cnt_o), 32'd2);
      addr_i = 32'h1020_2A00;
      tick();
      chk_out("hwpe3", 1'b1, 4'd12, 1'b0);

      req_valid_i = 1'b0; cfg_clr_i = 1'b1;
      tick();
      cfg_clr_i = 1'b0;
      chk("clr.cnt", 32'(err_cnt_o), 32'd0);
      chk("drain.valid", 32'(out_valid_o), 32'd0);

      // Out-of-window, extended and alias addresses
      req_valid_i = 1'b1; addr_i = 32'h1C00_0000;
      tick();
      chk_out("outside", 1'b1, 4'd8, 1'b0);
      addr_i = 32'h1040_0400;
      tick();
      chk_out("sub4", 1'b1, 4'd8, 1'b0);
      addrext_i = 32'h1; addr_i = 32'h1020_0400;
      tick();
      addrext_i = 32'h0;
      chk_out("addrext", 1'b1, 4'd8, 1'b0);
      addr_i = 32'h1B20_0800;
      tick();
      chk_out("alias", 1'b1, 4'd2, 1'b0);

      // Backpressure: new request pending, outputs hold
      out_ready_i = 1'b0; addr_i = 32'h1020_0C00;
      #1;
      chk("stall.ready", 32'(req_ready_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall.ready_c", 32'(req_ready_o), 32'd0);
         chk_out("stall", 1'b1, 4'd2, 1'b0);
         chk("stall.addr", out_addr_o, 32'h1B20_0800);
      end
      out_ready_i = 1'b1;
      #1;
      chk("release.ready", 32'(req_ready_o), 32'd1);
      tick();
      chk_out("release", 1'b1, 4'd3, 1'b0);
      chk("release.addr", out_addr_o, 32'h1020_0C00);
      req_valid_i = 1'b0;
      tick();
      chk("idle.valid", 32'(out_valid_o), 32'd0);

      // Reset during a stall
      cfg_we_i = 1'b1; cfg_mask_i = 4'b0000;
      tick();
      cfg_we_i = 1'b0;
      req_valid_i = 1'b1; addr_i = 32'h1020_2400;
      tick();
      chk_out("dis0", 1'b1, 4'd8, 1'b1);
      chk("dis0.cnt", 32'(err_cnt_o), 32'd1);
      req_valid_i = 1'b0; out_ready_i = 1'b0;
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("rst_stall.valid", 32'(out_valid_o), 32'd0);
      chk("rst_stall.mask", 32'(cfg_mask_o), 32'hF);
      chk("rst_stall.cnt", 32'(err_cnt_o), 32'd0);

      // Saturation
      out_ready_i = 1'b1; req_valid_i = 1'b1; addr_i = 32'h1020_3000;
      for (int i = 0; i < 65534; i++) tick();
      chk("sat.pre", 32'(err_cnt_o), 32'hFFFE);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sat", 32'(err_cnt_o), 32'hFFFF);
      end
      cfg_clr_i = 1'b1;
      tick();
      cfg_clr_i = 1'b0; req_valid_i = 1'b0;
      chk_out("clr_win", 1'b1, 4'd8, 1'b1);
      chk("clr_win.cnt", 32'(err_cnt_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
